vga_text_timing_gen: RTL and testbench
======================================

Name: vga_text_timing_gen

Overview:
- Raster timing source for the VGA text-mode path: generates 640x480@60 Hz counters, sync and blanking from the 50 MHz Avalon clock.
- Sits directly upstream of the text-mode Avalon-MM display interface, which consumes draw_x/draw_y to address VRAM and the font ROM.
- hs/vs/blank are delayed by a configurable number of pixel ticks so they stay aligned with the downstream VRAM-to-font-ROM-to-colour pipeline.
- Also exports a per-frame toggle and a frame-start pulse for software synchronisation.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIPE_DELAY, 2, pixel ticks of delay on hs/vs/blank; legal range 1..8

Ports:
- CLK  in  1  50 MHz system/Avalon clock
- RESET  in  1  synchronous, active-high reset
- pix_ce  out  1  pixel clock enable, high every second CLK
- draw_x  out  10  current horizontal count, 0..799
- draw_y  out  10  current vertical count, 0..524
- hs  out  1  hsync, active low, delayed PIPE_DELAY ticks
- vs  out  1  vsync, active low, delayed PIPE_DELAY ticks
- blank  out  1  high outside visible area, delayed PIPE_DELAY ticks
- frame_toggle  out  1  inverts once per frame
- frame_start  out  1  one-CLK pulse at start of each frame

Behaviour:
- One clock (CLK). Reset is synchronous and active-high on RESET; all state is cleared on the CLK edge where RESET=1.
- Reset values:
  - pix_ce=0, draw_x=0, draw_y=0
  - hs=1, vs=1, blank=1 (including every delay-line stage)
  - frame_toggle=0, frame_start=0
- pix_ce is a registered toggle:
  - 0 in the first CLK after RESET falls, then alternates 1,0,1,...
  - All counter and delay-line updates occur only on CLK edges where pix_ce=1.
- Derived totals: H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = sum of the V_* parameters = 525.
- Horizontal counter: draw_x increments by 1 and wraps from H_TOTAL-1 to 0.
- Vertical counter:
  - draw_y increments only on the tick where draw_x wraps.
  - It wraps from V_TOTAL-1 to 0 on the same tick.
- Raw conditions, combinational from the counters:
  - hs_raw = 0 iff H_VISIBLE+H_FRONT <= draw_x < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs_raw = 0 iff V_VISIBLE+V_FRONT <= draw_y < ...+V_SYNC (490..491).
  - blank_raw = 1 iff draw_x >= H_VISIBLE or draw_y >= V_VISIBLE.
- Delay line:
  - hs_raw, vs_raw and blank_raw each pass through a PIPE_DELAY-deep shift register clocked by pix_ce.
  - Outputs are the last stage.
  - Total latency from counter value to output is exactly PIPE_DELAY pixel ticks (2*PIPE_DELAY CLKs).
- frame_start:
  - Registered; 1 for exactly one CLK following the pix_ce tick in which the counters move from (799,524) to (0,0).
  - Not asserted for the (0,0) state entered by reset.
- frame_toggle inverts in the CLK where vs_raw first goes 0, i.e. draw_y becomes 490 with draw_x=0.
- Counters are 10 bits. Overflow beyond H_TOTAL-1/V_TOTAL-1 is impossible; any out-of-range value forces a wrap to 0 on the next tick.
- RESET asserted mid-frame: next CLK returns every output to its reset value; no partial frame_start pulse is emitted.

Optional Feature:
- Macro: VGA_TIMING_SCANLINE_CMP_EN.
- When defined:
  - Adds input line_cmp [9:0] and output line_hit [0:0].
  - line_hit is a one-CLK registered pulse when draw_y changes to a value equal to line_cmp, i.e. on the draw_x wrap tick.
  - line_cmp >= V_TOTAL never produces line_hit.
  - line_hit resets to 0.
- When undefined: neither port exists and there is no comparator logic.

Test Plan:
- Reset release: pix_ce=0 at the first CLK, then toggles. Expect draw_x=1 after CLK 2. hs=vs=blank=1 until PIPE_DELAY ticks elapse; blank=0 at tick 2 with PIPE_DELAY=2.
- Line timing: run 800 ticks. hs=0 for exactly 96 ticks, with its first low on the tick where draw_x=658 (PIPE_DELAY=2). draw_y increments once at the draw_x 799->0 wrap.
- Frame timing: run 420000 ticks, i.e. one frame. vs low for 2 lines (1600 ticks). frame_toggle flips once. frame_start is high for exactly 1 CLK at the (799,524)->(0,0) transition.
- Blanking: blank=0 for exactly 640*480=307200 ticks per frame. blank=1 at draw_x=640+2 on lines 0..479, and for all of lines 480..524.
- Mid-frame reset: assert RESET for 1 CLK at draw_y=300, draw_x=123. Next CLK: all outputs equal reset values, no frame_start, frame_toggle=0.
- With VGA_TIMING_SCANLINE_CMP_EN:
  - line_cmp=479: exactly one line_hit per frame, in the CLK after draw_y becomes 479.
  - line_cmp=600: line_hit never asserts.

Source files
------------

// File: rtl/vga_text_timing_gen.sv
// vga_text_timing_gen: raster timing for the VGA text path (640x480@60 by
// default, run from a 2x pixel clock via the pix_ce enable).
// Counters draw_x/draw_y address VRAM and the font ROM directly; hs/vs/blank
// are delayed PIPE_DELAY pixel ticks to line up with that fetch pipeline.
// Optional: define VGA_TIMING_SCANLINE_CMP_EN to add line_cmp/line_hit.

// One sync lane of the alignment delay line. It shifts only on pixel ticks
// and resets every stage high, so sync/blank read inactive/blanked until the
// first real sample has travelled through.
module vga_text_timing_dly #(
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ce,
    input  logic din,
    output logic dout
);

    logic [DEPTH:1] dly_pipe;

    // Shift register, stage 1 takes the raw level, stage DEPTH drives out.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dly_pipe <= '1;
        end else if (ce) begin
            dly_pipe[1] <= din;
            for (int i = 2; i <= DEPTH; i++) begin
                dly_pipe[i] <= dly_pipe[i-1];
            end
        end
    end

    assign dout = dly_pipe[DEPTH];

endmodule

module vga_text_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2     // 1..8 pixel ticks
) (
    input  logic       CLK,
    input  logic       RESET,
`ifdef VGA_TIMING_SCANLINE_CMP_EN
    input  logic [9:0] line_cmp,
    output logic       line_hit,
`endif
    output logic       pix_ce,
    output logic [9:0] draw_x,
    output logic [9:0] draw_y,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_toggle,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Sync lanes carried through the delay line.
    localparam int NUM_LANES = 3;
    localparam int LANE_HS   = 0;
    localparam int LANE_VS   = 1;
    localparam int LANE_BLK  = 2;

    logic                 h_wrap;
    logic                 v_wrap;
    logic [9:0]           x_nxt;
    logic [9:0]           y_nxt;
    logic [NUM_LANES-1:0] sync_raw;
    logic [NUM_LANES-1:0] sync_dly;

    // Pixel enable: half-rate toggle, low in the first cycle out of reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pix_ce <= 1'b0;
        end else begin
            pix_ce <= ~pix_ce;
        end
    end

    // Next counter values; ">=" folds any out-of-range count into a wrap.
    always_comb begin
        h_wrap = (draw_x >= H_LAST);
        v_wrap = (draw_y >= V_LAST);
        x_nxt  = h_wrap ? 10'd0 : 10'(draw_x + 10'd1);
        y_nxt  = draw_y;
        if (h_wrap) begin
            y_nxt = v_wrap ? 10'd0 : 10'(draw_y + 10'd1);
        end
    end

    // Raster counters advance on pixel ticks only.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            draw_x <= '0;
            draw_y <= '0;
        end else if (pix_ce) begin
            draw_x <= x_nxt;
            draw_y <= y_nxt;
        end
    end

    // Undelayed sync/blank levels decoded from the current counters.
    always_comb begin
        sync_raw           = '0;
        sync_raw[LANE_HS]  = ~((draw_x >= HS_START) && (draw_x < HS_END));
        sync_raw[LANE_VS]  = ~((draw_y >= VS_START) && (draw_y < VS_END));
        sync_raw[LANE_BLK] = (draw_x >= H_VIS) || (draw_y >= V_VIS);
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        vga_text_timing_dly #(
            .DEPTH (PIPE_DELAY)
        ) u_dly (
            .CLK   (CLK),
            .RESET (RESET),
            .ce    (pix_ce),
            .din   (sync_raw[g]),
            .dout  (sync_dly[g])
        );
    end

    assign hs    = sync_dly[LANE_HS];
    assign vs    = sync_dly[LANE_VS];
    assign blank = sync_dly[LANE_BLK];

    // Frame-start pulse on the last-pixel -> origin tick; it lasts one CLK
    // because the following edge never carries pix_ce. Reset entry to (0,0)
    // is not a counter move, so it never fires here.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && h_wrap && v_wrap;
        end
    end

    // Frame toggle flips on the same tick the counters enter the first
    // vsync line, i.e. together with the first low vs_raw level.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_toggle <= 1'b0;
        end else if (pix_ce && h_wrap && (y_nxt == VS_START)) begin
            frame_toggle <= ~frame_toggle;
        end
    end

`ifdef VGA_TIMING_SCANLINE_CMP_EN
    // Scanline hit: pulse when draw_y steps onto line_cmp. y_nxt never
    // exceeds V_TOTAL-1, so an out-of-range compare value never matches.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            line_hit <= 1'b0;
        end else begin
            line_hit <= pix_ce && h_wrap && (y_nxt == line_cmp);
        end
    end
`endif

endmodule

// File: tb/tb_vga_text_timing_gen.sv
// Randomized reset/run segments against an arithmetic raster model. A
// reduced raster keeps whole frames (and frame wraps) short.
module tb_vga_text_timing_gen;

  localparam int HV = 20, HF = 3, HSW = 5, HB = 4;
  localparam int VV = 12, VF = 2, VSW = 2, VB = 3;
  localparam int PD = 2;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam int FR = HT * VT;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       pix_ce;
  logic [9:0] draw_x, draw_y;
  logic       hs, vs, blank, frame_toggle, frame_start;
`ifdef VGA_TIMING_SCANLINE_CMP_EN
  logic [9:0] line_cmp = 10'd0;
  logic       line_hit;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  vga_text_timing_gen #(
    .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HSW), .H_BACK (HB),
    .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB),
    .PIPE_DELAY(PD)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
`ifdef VGA_TIMING_SCANLINE_CMP_EN
    .line_cmp    (line_cmp),
    .line_hit    (line_hit),
`endif
    .pix_ce      (pix_ce),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .hs          (hs),
    .vs          (vs),
    .blank       (blank),
    .frame_toggle(frame_toggle),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Raster position of pixel tick n after reset.
  function automatic int px(input int n); return n % HT; endfunction
  function automatic int py(input int n); return (n / HT) % VT; endfunction

  // Delayed outputs: inactive/blanked until PD ticks have elapsed.
  function automatic int hs_at(input int n);
    int x;
    if (n < PD) return 1;
    x = px(n - PD);
    return (x >= HV + HF && x < HV + HF + HSW) ? 0 : 1;
  endfunction

  function automatic int vs_at(input int n);
    int y;
    if (n < PD) return 1;
    y = py(n - PD);
    return (y >= VV + VF && y < VV + VF + VSW) ? 0 : 1;
  endfunction

  function automatic int blank_at(input int n);
    if (n < PD) return 1;
    return (px(n - PD) >= HV || py(n - PD) >= VV) ? 1 : 0;
  endfunction

  // Parity of ticks in 1..n landing on (0, first vsync line).
  function automatic int toggle_at(input int n);
    int t;
    t = (VV + VF) * HT;
    if (n < t) return 0;
    return ((n - t) / FR + 1) % 2;
  endfunction

  // k = CLK edges since the last reset edge; state sampled after edge k.
  task automatic check_cycle(input int k);
    int n;
    bit tick;
    n = k / 2;
    tick = (k % 2 == 0) && (n > 0);
    chk($sformatf("pix_ce k=%0d", k), pix_ce, k % 2);
    chk($sformatf("draw_x k=%0d", k), draw_x, px(n));
    chk($sformatf("draw_y k=%0d", k), draw_y, py(n));
    chk($sformatf("hs k=%0d", k), hs, hs_at(n));
    chk($sformatf("vs k=%0d", k), vs, vs_at(n));
    chk($sformatf("blank k=%0d", k), blank, blank_at(n));
    chk($sformatf("frame_toggle k=%0d", k), frame_toggle, toggle_at(n));
    chk($sformatf("frame_start k=%0d", k), frame_start,
        (tick && (n % FR == 0)) ? 1 : 0);
`ifdef VGA_TIMING_SCANLINE_CMP_EN
    chk($sformatf("line_hit k=%0d cmp=%0d", k, line_cmp), line_hit,
        (tick && px(n) == 0 && py(n) == int'(line_cmp)) ? 1 : 0);
`endif
  endtask

  initial begin
    int k;
    int len;
    int hold;
    int fs_cnt;
    for (int seg = 0; seg < 10; seg++) begin
      RESET = 1'b1;
`ifdef VGA_TIMING_SCANLINE_CMP_EN
      if (seg == 0)      line_cmp = 10'(VV - 1);
      else if (seg == 1) line_cmp = 10'(VT + 5);
      else               line_cmp = 10'($urandom_range(0, VT + 2));
`endif
      hold = $urandom_range(1, 3);
      repeat (hold) begin
        @(posedge CLK); #1;
        check_cycle(0);
      end
      RESET = 1'b0;
      k = 0;
      fs_cnt = 0;
      // seg 0: several full frames; seg 1: stop mid-frame at a known pixel.
      if (seg == 0)      len = 4 * FR * 2 + 10;
      else if (seg == 1) len = 2 * (7 * HT + 9) + 1;
      else               len = $urandom_range(50, 3 * FR);
      repeat (len) begin
        @(posedge CLK); #1;
        k++;
        check_cycle(k);
        if (frame_start) fs_cnt++;
      end
      if (seg == 0) chk("frame_start count over 4 frames", fs_cnt, 4);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
